// File: rtl/id_stage_pipe_pkg.sv
// Package id_pkg: MIPS32 opcode/function constants, ALU operation codes and
// the decoded-fields struct shared by the decode stage.
// The struct is sized for a 32-bit instruction word and 5-bit register
// addresses; the stage resizes fields to its own parameters where needed.
package id_pkg;

  localparam int ALU_W = 5;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  // SPECIAL function codes (inst[5:0])
  localparam logic [5:0] FUNC_SLL  = 6'h00;
  localparam logic [5:0] FUNC_SRL  = 6'h02;
  localparam logic [5:0] FUNC_SRA  = 6'h03;
  localparam logic [5:0] FUNC_SLLV = 6'h04;
  localparam logic [5:0] FUNC_SRLV = 6'h06;
  localparam logic [5:0] FUNC_SRAV = 6'h07;
  localparam logic [5:0] FUNC_AND  = 6'h24;
  localparam logic [5:0] FUNC_OR   = 6'h25;
  localparam logic [5:0] FUNC_XOR  = 6'h26;
  localparam logic [5:0] FUNC_NOR  = 6'h27;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_NOP = 5'd0;
  localparam logic [ALU_W-1:0] ALU_AND = 5'd1;
  localparam logic [ALU_W-1:0] ALU_OR  = 5'd2;
  localparam logic [ALU_W-1:0] ALU_XOR = 5'd3;
  localparam logic [ALU_W-1:0] ALU_NOR = 5'd4;
  localparam logic [ALU_W-1:0] ALU_SLL = 5'd5;
  localparam logic [ALU_W-1:0] ALU_SRL = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SRA = 5'd7;
  localparam logic [ALU_W-1:0] ALU_LUI = 5'd8;

  typedef struct packed {
    logic             ren1;     // read port 1 enabled (else op1 = imm)
    logic             ren2;     // read port 2 enabled (else op2 = imm)
    logic [4:0]       raddr1;
    logic [4:0]       raddr2;
    logic [31:0]      imm;
    logic [4:0]       waddr;
    logic             we;
    logic [ALU_W-1:0] aluop;
    logic             is_br;    // J, BEQ or BNE
    logic             illegal;
  } dec_t;

endpackage

// File: rtl/id_stage_pipe_fwd_mux.sv
// id_fwd_mux: resolves one read-port operand.
//   ren/imm           : disabled port passes imm through
//   raddr/rf_rdata    : register-file address and its same-cycle data
//   fwd_*             : NUM_FWD packed forwarding sources, index 0 youngest
//   operand           : resolved value
//   load_hit          : the winning source is a load whose data is not ready
module id_fwd_mux
  import id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                       ren,
  input  logic [RADDR_W-1:0]         raddr,
  input  logic [DATA_W-1:0]          rf_rdata,
  input  logic [DATA_W-1:0]          imm,
  input  logic [NUM_FWD-1:0]         fwd_we,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata,
  input  logic [NUM_FWD-1:0]         fwd_load,
  output logic [DATA_W-1:0]          operand,
  output logic                       load_hit
);

  always_comb begin
    operand  = rf_rdata;
    load_hit = 1'b0;
    // Walk from oldest to youngest so the lowest matching index wins.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_waddr[i*RADDR_W +: RADDR_W] == raddr)) begin
        operand  = fwd_wdata[i*DATA_W +: DATA_W];
        load_hit = fwd_load[i];
      end
    end
    // r0 is hard-wired zero whatever any source claims to write.
    if (raddr == '0) begin
      operand  = '0;
      load_hit = 1'b0;
    end
    if (!ren) begin
      operand  = imm;
      load_hit = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS32 decode stage with register-file read, operand
// forwarding, load-use stall, J/BEQ/BNE resolution and an ID/EX register.
//   in_valid/in_ready/inst_i/pc_i : instruction from IF/ID
//   rf_raddr*_o / rf_rdata*_i     : combinational register-file read
//   fwd_*_i                       : forwarding sources (0 = youngest)
//   flush_i                       : kill held and incoming instruction
//   out_valid/out_ready + fields  : registered ID/EX outputs
//   br_valid_o/br_target_o        : one-cycle fetch redirect
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and the producer holds its data
// stable while valid && !ready.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int NUM_FWD = 2,
  parameter int ALUOP_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                inst_i,
  input  logic [DATA_W-1:0]          pc_i,
  output logic [RADDR_W-1:0]         rf_raddr1_o,
  output logic [RADDR_W-1:0]         rf_raddr2_o,
  input  logic [DATA_W-1:0]          rf_rdata1_i,
  input  logic [DATA_W-1:0]          rf_rdata2_i,
  input  logic [NUM_FWD-1:0]         fwd_we_i,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_waddr_i,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata_i,
  input  logic [NUM_FWD-1:0]         fwd_load_i,
  input  logic                       flush_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          op1_o,
  output logic [DATA_W-1:0]          op2_o,
  output logic [RADDR_W-1:0]         waddr_o,
  output logic                       we_o,
  output logic [ALUOP_W-1:0]         aluop_o,
  output logic                       illegal_o,
  output logic                       br_valid_o,
  output logic [DATA_W-1:0]          br_target_o
);

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d        = '0;
    d.raddr1 = inst[25:21];
    d.raddr2 = inst[20:16];
    case (inst[31:26])
      OP_SPECIAL: begin
        d.ren1  = 1'b1;
        d.ren2  = 1'b1;
        d.waddr = inst[15:11];
        d.we    = 1'b1;
        case (inst[5:0])
          FUNC_AND:  d.aluop = ALU_AND;
          FUNC_OR:   d.aluop = ALU_OR;
          FUNC_XOR:  d.aluop = ALU_XOR;
          FUNC_NOR:  d.aluop = ALU_NOR;
          FUNC_SLLV: d.aluop = ALU_SLL;
          FUNC_SRLV: d.aluop = ALU_SRL;
          FUNC_SRAV: d.aluop = ALU_SRA;
          // Immediate shifts: shamt travels on op1 via the imm path.
          FUNC_SLL, FUNC_SRL, FUNC_SRA: begin
            d.ren1  = 1'b0;
            d.imm   = {27'd0, inst[10:6]};
            d.aluop = (inst[5:0] == FUNC_SLL) ? ALU_SLL :
                      (inst[5:0] == FUNC_SRL) ? ALU_SRL : ALU_SRA;
          end
          default:   d.illegal = 1'b1;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.ren1  = 1'b1;
        d.imm   = {16'd0, inst[15:0]};
        d.waddr = inst[20:16];
        d.we    = 1'b1;
        d.aluop = (inst[31:26] == OP_ANDI) ? ALU_AND :
                  (inst[31:26] == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        d.imm   = {inst[15:0], 16'd0};
        d.waddr = inst[20:16];
        d.we    = 1'b1;
        d.aluop = ALU_LUI;
      end
      OP_J:   d.is_br = 1'b1;
      OP_BEQ, OP_BNE: begin
        d.ren1  = 1'b1;
        d.ren2  = 1'b1;
        d.is_br = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    // Illegal words flow down the pipe as harmless bubbles.
    if (d.illegal) begin
      d.ren1  = 1'b0;
      d.ren2  = 1'b0;
      d.imm   = '0;
      d.waddr = '0;
      d.we    = 1'b0;
      d.aluop = ALU_NOP;
    end
    return d;
  endfunction

  dec_t              dec;
  logic [DATA_W-1:0] imm_ext, opnd1, opnd2;
  logic              hit1, hit2, stall, accept, taken, is_j;
  logic [DATA_W-1:0] pc4, br_off, target;

  assign dec         = decode(inst_i);
  assign rf_raddr1_o = RADDR_W'(dec.raddr1);
  assign rf_raddr2_o = RADDR_W'(dec.raddr2);
  assign imm_ext     = DATA_W'(dec.imm);

  id_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .ren(dec.ren1), .raddr(rf_raddr1_o), .rf_rdata(rf_rdata1_i), .imm(imm_ext),
    .fwd_we(fwd_we_i), .fwd_waddr(fwd_waddr_i), .fwd_wdata(fwd_wdata_i),
    .fwd_load(fwd_load_i), .operand(opnd1), .load_hit(hit1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .ren(dec.ren2), .raddr(rf_raddr2_o), .rf_rdata(rf_rdata2_i), .imm(imm_ext),
    .fwd_we(fwd_we_i), .fwd_waddr(fwd_waddr_i), .fwd_wdata(fwd_wdata_i),
    .fwd_load(fwd_load_i), .operand(opnd2), .load_hit(hit2)
  );

  assign stall    = hit1 | hit2;
  assign in_ready = !stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Branch resolution; pc_i is at least 32 bits wide here.
  assign is_j   = (inst_i[31:26] == OP_J);
  assign pc4    = pc_i + DATA_W'(4);
  assign br_off = {{(DATA_W-18){inst_i[15]}}, inst_i[15:0], 2'b00};
  assign target = is_j ? {pc4[DATA_W-1:28], inst_i[25:0], 2'b00} : pc4 + br_off;
  assign taken  = dec.is_br && (is_j ||
                  ((inst_i[31:26] == OP_BEQ) && (opnd1 == opnd2)) ||
                  ((inst_i[31:26] == OP_BNE) && (opnd1 != opnd2)));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      op1_o       <= '0;
      op2_o       <= '0;
      waddr_o     <= '0;
      we_o        <= 1'b0;
      aluop_o     <= '0;
      illegal_o   <= 1'b0;
      br_valid_o  <= 1'b0;
      br_target_o <= '0;
    end else if (flush_i) begin
      out_valid  <= 1'b0;
      br_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      op1_o       <= opnd1;
      op2_o       <= opnd2;
      waddr_o     <= RADDR_W'(dec.waddr);
      we_o        <= dec.we;
      aluop_o     <= ALUOP_W'(dec.aluop);
      illegal_o   <= dec.illegal;
      br_valid_o  <= taken;
      br_target_o <= target;
    end else begin
      br_valid_o <= 1'b0;
      if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule
